// File: rtl/column_memory_pkg.sv
// Shared column memory definitions: memory action codes, polarity codes and
// the state encoding of the column readout FSM.
package column_memory_pkg;

    typedef enum logic [2:0] {
        ACT_NONE       = 3'd0,
        ACT_ACCUMULATE = 3'd1,
        ACT_FILTER     = 3'd2,
        ACT_CLEAR      = 3'd3
    } action_t;

    typedef enum logic {
        POL_POSITIVE = 1'b0,
        POL_NEGATIVE = 1'b1
    } polarity_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with occupancy count; the head word is presented
// combinationally and holds until popped.
module stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign valid    = (count != '0);
    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/column_memory_reader.sv
// Streams one frame of column memory out over AXI-Stream, optionally issuing
// a CLEAR action for every word after it has been read.
module column_memory_reader
    import column_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int n          = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] addrb_o,
    input  logic signed [n-1:0]   dob_i,
    output logic [2:0]            action_o,
    output logic [ADDR_WIDTH-1:0] addra_o,
    output logic signed [n-1:0]   m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    // state    | meaning
    // ST_IDLE  | waiting for start_i
    // ST_SCAN  | issuing reads while buffer credit allows
    // ST_DRAIN | last read issued, waiting for the tlast handshake

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;

    reader_state_t         state, state_next;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  rd_pending;
    logic                  clear_lat;
    logic                  done_q;
    logic                  issue;
    logic                  credit_ok;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        occ_sum;
    logic                  fifo_valid;
    logic                  fifo_pop;
    logic [n:0]            fifo_head;
    logic [n:0]            fifo_in;

    // A read may only go out if its data is guaranteed a free buffer slot.
    assign occ_sum   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending};
    assign credit_ok = (occ_sum < (CNT_W + 1)'(DEPTH));
    assign fifo_pop  = fifo_valid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (addr_cnt == MAX_ADDR) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_pop && fifo_head[n]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_cnt   <= '0;
            pend_addr  <= '0;
            rd_pending <= 1'b0;
            clear_lat  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_pending <= issue;
            done_q     <= (state == ST_DRAIN) && (state_next == ST_IDLE);
            if (issue) begin
                pend_addr <= addr_cnt;
            end
            // The counter saturates on the last address; only a new start rewinds it.
            if (state == ST_IDLE && start_i) begin
                addr_cnt  <= '0;
                clear_lat <= clear_i;
            end else if (issue && addr_cnt != MAX_ADDR) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    assign fifo_in = {(pend_addr == MAX_ADDR), dob_i};

    stream_fifo #(
        .WIDTH (n + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .push      (rd_pending),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign busy_o        = (state != ST_IDLE);
    assign done_o        = done_q;
    assign addrb_o       = addr_cnt;
    assign action_o      = (rd_pending && clear_lat) ? ACT_CLEAR : ACT_NONE;
    assign addra_o       = (rd_pending && clear_lat) ? pend_addr : '0;
    assign m_axis_tvalid = fifo_valid;
    assign m_axis_tdata  = fifo_valid ? fifo_head[n-1:0] : '0;
    assign m_axis_tlast  = fifo_valid && fifo_head[n];

endmodule

// File: tb/tb_column_memory_reader.sv
// Bench for column_memory_reader: an 8-word memory stub plus a frame-level
// model of the expected stream, clear actions and done pulse.
module tb_column_memory_reader;
    import column_memory_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               clear;
    logic               busy;
    logic               done;
    logic [2:0]         addrb;
    logic signed [15:0] dob;
    logic [2:0]         action;
    logic [2:0]         addra;
    logic signed [15:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;

    column_memory_reader #(
        .ADDR_WIDTH (3),
        .n          (16),
        .DEPTH      (4)
    ) dut (
        .clk           (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .clear_i       (clear),
        .busy_o        (busy),
        .done_o        (done),
        .addrb_o       (addrb),
        .dob_i         (dob),
        .action_o      (action),
        .addra_o       (addra),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Memory stub: one-cycle read latency, CLEAR zeroes the addressed word.
    logic signed [15:0] mem_y    [8];
    logic signed [15:0] load_buf [8];
    logic               load_en;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 8; i++) mem_y[i] <= load_buf[i];
        end else if (action == ACT_CLEAR) begin
            mem_y[addra] <= '0;
        end
        dob <= mem_y[addrb];
    end

    // Frame-level model state.
    logic signed [15:0] model_mem [8];
    logic signed [15:0] exp_data  [8];
    logic signed [15:0] cap       [8];
    int  clr_hits [8];
    bit  exp_clear;
    int  beat;
    int  done_cnt;
    int  cyc;
    int  first_cyc;
    int  last_cyc;
    int  rmode;
    int  tcnt;
    bit  stall_prev;
    logic signed [15:0] stall_data;

    always @(posedge clk) cyc++;

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: tready = 1'b1;
                1: begin
                    tready = (tcnt % 3 == 0);
                    tcnt++;
                end
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk(tvalid == 1'b1, "hold_valid", int'(tvalid), 1);
                chk(tdata == stall_data, "hold_data", int'(tdata), int'(stall_data));
            end
            if (tvalid && tready) begin
                if (beat < 8) begin
                    cap[beat] = tdata;
                    chk(tdata == exp_data[beat], "tdata", int'(tdata), int'(exp_data[beat]));
                    chk(tlast == (beat == 7), "tlast", int'(tlast), int'(beat == 7));
                    if (beat == 0) first_cyc = cyc;
                    last_cyc = cyc;
                end else begin
                    chk(1'b0, "extra_beat", beat + 1, 8);
                end
                beat++;
            end
            stall_prev = tvalid && !tready;
            stall_data = tdata;
            chk(action == ACT_NONE || action == ACT_CLEAR, "action_code", int'(action), 0);
            if (action == ACT_CLEAR) begin
                if (exp_clear) clr_hits[addra]++;
                else chk(1'b0, "unexpected_clear", int'(addra), -1);
            end
            if (done) begin
                done_cnt++;
                chk(busy == 1'b0, "done_busy_low", int'(busy), 0);
            end
        end
    end

    task automatic load_frame();
        for (int i = 0; i < 8; i++) model_mem[i] = load_buf[i];
        @(posedge clk);
        #1 load_en = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic pulse_start(input bit c);
        @(posedge clk);
        #1;
        start = 1'b1;
        clear = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic arm_frame(input bit clr, input int mode);
        for (int i = 0; i < 8; i++) begin
            exp_data[i] = model_mem[i];
            clr_hits[i] = 0;
            cap[i]      = 'x;
        end
        exp_clear = clr;
        beat      = 0;
        tcnt      = 0;
        rmode     = mode;
        if (clr) begin
            for (int i = 0; i < 8; i++) model_mem[i] = '0;
        end
    endtask

    task automatic run_frame(input bit clr, input int mode, input bit restart);
        int d0;
        d0 = done_cnt;
        arm_frame(clr, mode);
        pulse_start(clr);
        @(negedge clk);
        chk(busy == 1'b1, "busy_rise", int'(busy), 1);
        if (restart) begin
            repeat (4) @(posedge clk);
            #1;
            chk(busy == 1'b1, "busy_at_restart", int'(busy), 1);
            start = 1'b1;
            clear = !clr;
            @(posedge clk);
            #1;
            start = 1'b0;
            clear = 1'b0;
        end
        for (int k = 0; k < 500 && done_cnt == d0; k++) @(negedge clk);
        chk(done_cnt == d0 + 1, "done_timeout", done_cnt - d0, 1);
        chk(beat == 8, "beat_count", beat, 8);
        if (clr) begin
            for (int i = 0; i < 8; i++) chk(clr_hits[i] == 1, "clear_once", clr_hits[i], 1);
        end
        if (mode == 0) chk(last_cyc - first_cyc == 7, "throughput", last_cyc - first_cyc, 7);
        repeat (3) @(negedge clk);
        chk(done_cnt == d0 + 1, "single_done", done_cnt - d0, 1);
        chk(busy == 1'b0, "busy_fall", int'(busy), 0);
        exp_clear = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({busy, done, tvalid, tlast, tdata, action, addrb, addra} == '0, nm,
            int'({busy, done, tvalid, tlast, tdata, action, addrb, addra}), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        load_en   = 1'b0;
        rmode     = 0;
        tcnt      = 0;
        beat      = 0;
        done_cnt  = 0;
        cyc       = 0;
        first_cyc = 0;
        last_cyc  = 0;
        exp_clear = 1'b0;
        for (int i = 0; i < 8; i++) load_buf[i] = 16'(16 * i);
        #22;
        chk_quiet("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp frame, tready high.
        load_frame();
        run_frame(1'b0, 0, 1'b0);
        chk(cap[0] == 16'sd0, "ramp_first", int'(cap[0]), 0);
        chk(cap[3] == 16'sd48, "ramp_mid", int'(cap[3]), 48);
        chk(cap[7] == 16'sd112, "ramp_last", int'(cap[7]), 112);

        // Same frame with tready 1,0,0 pattern.
        run_frame(1'b0, 1, 1'b0);

        // Negative word.
        load_buf[5] = 16'hFFFF;
        load_frame();
        run_frame(1'b0, 0, 1'b0);
        chk(cap[5] == 16'hFFFF, "neg_word", int'(cap[5]), -1);

        // Clear frame then readback of zeros.
        for (int i = 0; i < 8; i++) load_buf[i] = 16'(16 * i);
        load_frame();
        run_frame(1'b1, 1, 1'b0);
        chk(cap[6] == 16'sd96, "clear_frame_data", int'(cap[6]), 96);
        run_frame(1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++) chk(cap[i] == 16'sd0, "cleared_word", int'(cap[i]), 0);

        // Start pulsed mid-frame.
        load_frame();
        run_frame(1'b0, 0, 1'b1);

        // Reset after the third beat.
        arm_frame(1'b0, 1);
        pulse_start(1'b0);
        for (int k = 0; k < 200 && beat < 3; k++) @(negedge clk);
        chk(beat >= 3, "beats_before_reset", beat, 3);
        #2 rst_n = 1'b0;
        #1 chk_quiet("async_reset_outputs");
        repeat (2) @(negedge clk);
        chk_quiet("held_reset_outputs");
        rst_n = 1'b1;
        run_frame(1'b0, 0, 1'b0);

        // Randomised frames.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) load_buf[i] = 16'($urandom);
            load_frame();
            run_frame(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
